dimm_cmd_responder: RTL and testbench

//  DIMM-side endpoint of the DDR5 command bus driven by the memory scheduler.
//  - Assembles two-cycle commands: ACT0/ACT1, RD0/RD1, WR0/WR1; PRE is single-cycle.
//  - Tracks open-row state for all 32 banks and checks protocol timing.
//  - Produces the read-data return window and the write-data request window.
//  - Flags every protocol violation, so scheduler traces can be checked cycle-accurately.

---
 rtl/dimm_cmd_responder.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_dimm_cmd_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dimm_cmd_responder.sv
// DIMM-side DDR5 command endpoint: assembles two-half commands, tracks 32 banks and produces burst windows.
// Optional command counters are built only when DIMM_STATS_EN is defined.
module dimm_cmd_responder #(
    parameter int unsigned T_RCD   = 39,
    parameter int unsigned T_CL    = 40,
    parameter int unsigned T_CWL   = 38,
    parameter int unsigned T_WR    = 30,
    parameter int unsigned T_RP    = 39,
    parameter int unsigned T_BURST = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    input  logic [2:0]  i_cmd_op,
    input  logic        i_cmd_ch,
    input  logic [2:0]  i_cmd_bg,
    input  logic [1:0]  i_cmd_ba,
    input  logic [15:0] i_cmd_row,
    input  logic [9:0]  i_cmd_col,
    output logic        o_rd_valid,
    output logic        o_wr_req,
    output logic [2:0]  o_burst_bg,
    output logic [1:0]  o_burst_ba,
    output logic [9:0]  o_burst_col,
    output logic [2:0]  o_burst_beat,
    output logic        o_err_valid,
    output logic [2:0]  o_err_code,
    output logic [15:0] o_stat_act,
    output logic [15:0] o_stat_rd,
    output logic [15:0] o_stat_wr,
    output logic [15:0] o_stat_pre
);
    typedef enum logic [2:0] {
        OP_ACT0 = 3'd0, OP_ACT1 = 3'd1, OP_RD0 = 3'd2, OP_RD1 = 3'd3,
        OP_WR0  = 3'd4, OP_WR1  = 3'd5, OP_PRE = 3'd6, OP_RSV = 3'd7
    } op_e;
    typedef enum logic [1:0] {BK_IDLE, BK_ACTIVE, BK_PRECH} bank_e;
    typedef enum logic [1:0] {LAST_ACT, LAST_RD, LAST_WR} last_e;
    typedef enum logic [1:0] {P_NONE, P_WAIT1, P_WAIT2} pend_e;
    typedef enum logic [1:0] {B_IDLE, B_WAIT, B_ACTIVE} burst_e;

    localparam logic [7:0] L_RCD       = 8'(T_RCD);
    localparam logic [7:0] L_RD_REC    = 8'(T_CL + T_BURST);
    localparam logic [7:0] L_WR_REC    = 8'(T_CWL + T_BURST + T_WR);
    localparam logic [7:0] L_RP_M1     = 8'(T_RP - 1);
    localparam logic [7:0] L_CL_M1     = 8'(T_CL - 1);
    localparam logic [7:0] L_CWL_M1    = 8'(T_CWL - 1);
    localparam logic [2:0] L_LAST_BEAT = 3'(T_BURST - 1);

    bank_e       r_bank_st   [32];
    logic [7:0]  r_bank_tmr  [32];
    last_e       r_bank_last [32];

    pend_e       r_pst, w_pst_nxt;
    logic [2:0]  r_pend_op, r_pend_bg;
    logic [1:0]  r_pend_ba;
    logic        r_pend_ch;
    logic [15:0] r_pend_row;
    logic [9:0]  r_pend_col;

    burst_e      r_bst, w_bst_nxt;
    logic [7:0]  r_bwait;
    logic [2:0]  r_beat, r_b_bg;
    logic [1:0]  r_b_ba;
    logic [9:0]  r_b_col;
    logic        r_b_rd;

    logic        r_err_valid;
    logic [2:0]  r_err_code;

    logic [4:0]  w_bank, w_tgt;
    bank_e       w_st;
    logic [7:0]  w_tmr;
    last_e       w_last;
    logic        w_busy, w_rcd_ok, w_rec_ok, w_pair_ok;
    logic        w_err, w_pend_load, w_do_act, w_do_rd, w_do_wr, w_do_pre;
    logic [2:0]  w_code;

    assign w_bank   = {i_cmd_bg, i_cmd_ba};
    assign w_tgt    = (r_pst == P_WAIT2) ? {r_pend_bg, r_pend_ba} : w_bank;
    assign w_st     = r_bank_st[w_bank];
    assign w_tmr    = r_bank_tmr[w_bank];
    assign w_last   = r_bank_last[w_bank];
    assign w_busy   = (r_bst != B_IDLE);
    assign w_rcd_ok = (w_last != LAST_ACT) || (w_tmr >= L_RCD);

    // A second half on the other channel cannot belong to the pending command.
    assign w_pair_ok = i_cmd_valid && (i_cmd_op == r_pend_op + 3'd1) &&
                       (i_cmd_ch == r_pend_ch) && (i_cmd_bg == r_pend_bg) &&
                       (i_cmd_ba == r_pend_ba) &&
                       ((r_pend_op == OP_ACT0) ? (i_cmd_row == r_pend_row)
                                               : (i_cmd_col == r_pend_col));

    always_comb begin
        w_rec_ok = 1'b1;
        case (w_last)
            LAST_RD: w_rec_ok = (w_tmr >= L_RD_REC);
            LAST_WR: w_rec_ok = (w_tmr >= L_WR_REC);
            default: w_rec_ok = 1'b1;
        endcase
    end

    always_comb begin
        w_pst_nxt   = r_pst;
        w_err       = 1'b0;
        w_code      = '0;
        w_pend_load = 1'b0;
        w_do_act    = 1'b0;
        w_do_rd     = 1'b0;
        w_do_wr     = 1'b0;
        w_do_pre    = 1'b0;
        case (r_pst)
            P_WAIT1: begin
                w_pst_nxt = P_WAIT2;
                if (i_cmd_valid) begin
                    w_err     = 1'b1;
                    w_code    = 3'd4;
                    w_pst_nxt = P_NONE;
                end
            end
            P_WAIT2: begin
                w_pst_nxt = P_NONE;
                if (w_pair_ok) begin
                    case (r_pend_op)
                        OP_ACT0: w_do_act = 1'b1;
                        OP_RD0:  w_do_rd  = 1'b1;
                        OP_WR0:  w_do_wr  = 1'b1;
                        default: w_do_act = 1'b0;
                    endcase
                end else begin
                    w_err  = 1'b1;
                    w_code = 3'd4;
                end
            end
            default: begin
                if (i_cmd_valid) begin
                    case (i_cmd_op)
                        OP_ACT0: begin
                            if (w_st == BK_ACTIVE) begin
                                w_err = 1'b1; w_code = 3'd1;
                            end else if (w_st == BK_PRECH) begin
                                w_err = 1'b1; w_code = 3'd5;
                            end else begin
                                w_pend_load = 1'b1; w_pst_nxt = P_WAIT1;
                            end
                        end
                        OP_RD0, OP_WR0: begin
                            if (!((w_st == BK_ACTIVE) && w_rcd_ok)) begin
                                w_err = 1'b1; w_code = 3'd2;
                            end else if (w_busy) begin
                                w_err = 1'b1; w_code = 3'd6;
                            end else begin
                                w_pend_load = 1'b1; w_pst_nxt = P_WAIT1;
                            end
                        end
                        OP_PRE: begin
                            if ((w_st == BK_ACTIVE) && !w_rec_ok) begin
                                w_err = 1'b1; w_code = 3'd3;
                            end else begin
                                w_do_pre = 1'b1;
                            end
                        end
                        OP_RSV: begin
                            w_err = 1'b1; w_code = 3'd7;
                        end
                        default: begin
                            w_err = 1'b1; w_code = 3'd4;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pst      <= P_NONE;
            r_pend_op  <= '0;
            r_pend_bg  <= '0;
            r_pend_ba  <= '0;
            r_pend_ch  <= 1'b0;
            r_pend_row <= '0;
            r_pend_col <= '0;
        end else begin
            r_pst <= w_pst_nxt;
            if (w_pend_load) begin
                r_pend_op  <= i_cmd_op;
                r_pend_bg  <= i_cmd_bg;
                r_pend_ba  <= i_cmd_ba;
                r_pend_ch  <= i_cmd_ch;
                r_pend_row <= i_cmd_row;
                r_pend_col <= i_cmd_col;
            end
        end
    end

    // Each bank timer counts cycles since its last ACT1/RD1/WR1/PRE and saturates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_bank_st[i]   <= BK_IDLE;
                r_bank_tmr[i]  <= '0;
                r_bank_last[i] <= LAST_ACT;
            end
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (r_bank_tmr[i] != 8'hFF)
                    r_bank_tmr[i] <= r_bank_tmr[i] + 8'd1;
                if ((r_bank_st[i] == BK_PRECH) && (r_bank_tmr[i] >= L_RP_M1))
                    r_bank_st[i] <= BK_IDLE;
                if (5'(i) == w_tgt) begin
                    if (w_do_act) begin
                        r_bank_st[i]   <= BK_ACTIVE;
                        r_bank_tmr[i]  <= 8'd1;
                        r_bank_last[i] <= LAST_ACT;
                    end
                    if (w_do_rd || w_do_wr) begin
                        r_bank_tmr[i]  <= 8'd1;
                        r_bank_last[i] <= w_do_rd ? LAST_RD : LAST_WR;
                    end
                    if (w_do_pre && (r_bank_st[i] == BK_ACTIVE)) begin
                        r_bank_st[i]  <= BK_PRECH;
                        r_bank_tmr[i] <= 8'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_bst_nxt = r_bst;
        case (r_bst)
            B_WAIT:   if (r_bwait == 8'd1) w_bst_nxt = B_ACTIVE;
            B_ACTIVE: if (r_beat == L_LAST_BEAT) w_bst_nxt = B_IDLE;
            default:  if (w_do_rd || w_do_wr) w_bst_nxt = B_WAIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bst   <= B_IDLE;
            r_bwait <= '0;
            r_beat  <= '0;
            r_b_rd  <= 1'b0;
            r_b_bg  <= '0;
            r_b_ba  <= '0;
            r_b_col <= '0;
        end else begin
            r_bst <= w_bst_nxt;
            if ((r_bst == B_IDLE) && (w_do_rd || w_do_wr)) begin
                r_bwait <= w_do_rd ? L_CL_M1 : L_CWL_M1;
                r_beat  <= '0;
                r_b_rd  <= w_do_rd;
                r_b_bg  <= r_pend_bg;
                r_b_ba  <= r_pend_ba;
                r_b_col <= r_pend_col;
            end else if (r_bst == B_WAIT) begin
                r_bwait <= r_bwait - 8'd1;
            end else if (r_bst == B_ACTIVE) begin
                r_beat <= r_beat + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_valid <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_err_valid <= w_err;
            r_err_code  <= w_code;
        end
    end

    assign o_rd_valid   = (r_bst == B_ACTIVE) && r_b_rd;
    assign o_wr_req     = (r_bst == B_ACTIVE) && !r_b_rd;
    assign o_burst_bg   = (r_bst == B_ACTIVE) ? r_b_bg  : '0;
    assign o_burst_ba   = (r_bst == B_ACTIVE) ? r_b_ba  : '0;
    assign o_burst_col  = (r_bst == B_ACTIVE) ? r_b_col : '0;
    assign o_burst_beat = (r_bst == B_ACTIVE) ? r_beat  : '0;
    assign o_err_valid  = r_err_valid;
    assign o_err_code   = r_err_code;

`ifdef DIMM_STATS_EN
    logic [15:0] r_stat_act, r_stat_rd, r_stat_wr, r_stat_pre;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_act <= '0;
            r_stat_rd  <= '0;
            r_stat_wr  <= '0;
            r_stat_pre <= '0;
        end else begin
            if (w_do_act) r_stat_act <= r_stat_act + 16'd1;
            if (w_do_rd)  r_stat_rd  <= r_stat_rd + 16'd1;
            if (w_do_wr)  r_stat_wr  <= r_stat_wr + 16'd1;
            if (w_do_pre) r_stat_pre <= r_stat_pre + 16'd1;
        end
    end

    assign o_stat_act = r_stat_act;
    assign o_stat_rd  = r_stat_rd;
    assign o_stat_wr  = r_stat_wr;
    assign o_stat_pre = r_stat_pre;
`else
    assign o_stat_act = '0;
    assign o_stat_rd  = '0;
    assign o_stat_wr  = '0;
    assign o_stat_pre = '0;
`endif
endmodule

// File: tb/tb_dimm_cmd_responder.sv
// Table-driven bench for dimm_cmd_responder; error and burst expectations are queued when commands are driven.
module tb_dimm_cmd_responder;
    localparam int T_CL  = 40;
    localparam int T_CWL = 38;
    localparam logic [2:0] ACT0 = 3'd0, ACT1 = 3'd1, RD0 = 3'd2, RD1 = 3'd3;
    localparam logic [2:0] WR0 = 3'd4, WR1 = 3'd5, PRE = 3'd6, RSV = 3'd7;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ch;
    logic [2:0]  cmd_op, cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        rd_valid, wr_req, err_valid;
    logic [2:0]  burst_bg, burst_beat, err_code;
    logic [1:0]  burst_ba;
    logic [9:0]  burst_col;
    logic [15:0] stat_act, stat_rd, stat_wr, stat_pre;

    always #5 clk = ~clk;

    dimm_cmd_responder dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd_op(cmd_op),
        .i_cmd_ch(cmd_ch), .i_cmd_bg(cmd_bg), .i_cmd_ba(cmd_ba), .i_cmd_row(cmd_row),
        .i_cmd_col(cmd_col), .o_rd_valid(rd_valid), .o_wr_req(wr_req),
        .o_burst_bg(burst_bg), .o_burst_ba(burst_ba), .o_burst_col(burst_col),
        .o_burst_beat(burst_beat), .o_err_valid(err_valid), .o_err_code(err_code),
        .o_stat_act(stat_act), .o_stat_rd(stat_rd), .o_stat_wr(stat_wr), .o_stat_pre(stat_pre)
    );

    typedef struct {
        int          cyc;
        logic        valid;
        logic [2:0]  op;
        logic [2:0]  bg;
        logic [1:0]  ba;
        logic [15:0] row;
        logic [9:0]  col;
        int          exp_err;
    } vec_t;

    typedef struct { int cyc; int code; } err_t;

    typedef struct {
        int         cyc;
        logic       rd;
        logic [2:0] bg;
        logic [1:0] ba;
        logic [9:0] col;
        logic [2:0] beat;
    } beat_t;

    vec_t  vt[$];
    err_t  errq[$];
    beat_t bq[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void add(input int c, input logic v, input logic [2:0] op,
                                input logic [2:0] bg, input logic [1:0] ba,
                                input logic [15:0] row, input logic [9:0] col, input int e);
        vec_t x;
        x.cyc = c; x.valid = v; x.op = op; x.bg = bg; x.ba = ba;
        x.row = row; x.col = col; x.exp_err = e;
        vt.push_back(x);
    endfunction

    task automatic check_outputs();
        logic  ev;
        int    code;
        beat_t eb;
        while (errq.size() > 0 && errq[0].cyc < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL err_missed @cycle %0d: got none, expected code %0d", errq[0].cyc, errq[0].code);
            void'(errq.pop_front());
        end
        ev = 1'b0; code = 0;
        if (errq.size() > 0 && errq[0].cyc == cyc) begin
            ev = 1'b1; code = errq[0].code;
            void'(errq.pop_front());
        end
        chk("err_valid", 32'(err_valid), 32'(ev));
        if (ev) chk("err_code", 32'(err_code), code);

        while (bq.size() > 0 && bq[0].cyc < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL beat_missed @cycle %0d: got none, expected beat %0d", bq[0].cyc, bq[0].beat);
            void'(bq.pop_front());
        end
        eb = '{cyc, 1'b0, 3'd0, 2'd0, 10'd0, 3'd0};
        if (bq.size() > 0 && bq[0].cyc == cyc) begin
            eb = bq.pop_front();
            chk("rd_valid", 32'(rd_valid), 32'(eb.rd));
            chk("wr_req", 32'(wr_req), 32'(!eb.rd));
        end else begin
            chk("rd_valid", 32'(rd_valid), 0);
            chk("wr_req", 32'(wr_req), 0);
        end
        chk("burst_bg", 32'(burst_bg), 32'(eb.bg));
        chk("burst_ba", 32'(burst_ba), 32'(eb.ba));
        chk("burst_col", 32'(burst_col), 32'(eb.col));
        chk("burst_beat", 32'(burst_beat), 32'(eb.beat));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cyc++;
        check_outputs();
    endtask

    task automatic chk_stats(input int a, input int r, input int w, input int p);
`ifdef DIMM_STATS_EN
        chk("stat_act", 32'(stat_act), a);
        chk("stat_rd", 32'(stat_rd), r);
        chk("stat_wr", 32'(stat_wr), w);
        chk("stat_pre", 32'(stat_pre), p);
`else
        chk("stat_act", 32'(stat_act), 0);
        chk("stat_rd", 32'(stat_rd), 0);
        chk("stat_wr", 32'(stat_wr), 0);
        chk("stat_pre", 32'(stat_pre), 0);
        if (a + r + w + p < 0) $display("unreachable");
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        errq.delete();
        bq.delete();
        step();
        step();
        chk_stats(0, 0, 0, 0);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic drive(input vec_t v);
        if (v.valid) begin
            cmd_valid = 1'b1; cmd_op = v.op; cmd_bg = v.bg; cmd_ba = v.ba;
            cmd_row = v.row; cmd_col = v.col; cmd_ch = 1'b0;
        end
        if (v.exp_err != 0) errq.push_back('{cyc + 1, v.exp_err});
        if (v.valid && v.exp_err == 0 && (v.op == RD1 || v.op == WR1)) begin
            for (int b = 0; b < 8; b++)
                bq.push_back('{cyc + ((v.op == RD1) ? T_CL : T_CWL) + b, v.op == RD1,
                               v.bg, v.ba, v.col, 3'(b)});
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < vt.size(); i++) begin
            while (cyc < vt[i].cyc) step();
            drive(vt[i]);
        end
        step();
    endtask

    task automatic drain();
        repeat (60) step();
        chk("errq_drained", errq.size(), 0);
        chk("burstq_drained", bq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_ch = 1'b0; cmd_op = '0; cmd_bg = '0;
        cmd_ba = '0; cmd_row = '0; cmd_col = '0;

        // Read, precharge timing, burst-busy, reserved op, ACT on active, early RD.
        do_reset();
        vt.delete();
        add(10,  1, ACT0, 2, 1, 16'h1234, 0, 0);
        add(12,  1, ACT1, 2, 1, 16'h1234, 0, 0);
        add(20,  1, ACT0, 0, 0, 16'h0777, 0, 0);
        add(22,  1, ACT1, 0, 0, 16'h0777, 0, 0);
        add(51,  1, RD0,  2, 1, 0, 10'h155, 0);
        add(53,  1, RD1,  2, 1, 0, 10'h155, 0);
        add(65,  1, RSV,  1, 1, 0, 0, 7);
        add(70,  1, RD0,  0, 0, 0, 10'h011, 6);
        add(75,  1, ACT0, 0, 0, 16'h0777, 0, 1);
        add(80,  1, RD0,  7, 3, 0, 10'h001, 2);
        add(95,  1, RD0,  0, 0, 0, 10'h011, 6);
        add(101, 1, PRE,  2, 1, 0, 0, 0);
        add(139, 1, ACT0, 2, 1, 16'h2222, 0, 5);
        add(140, 1, ACT0, 2, 1, 16'h2222, 0, 0);
        add(142, 1, ACT1, 2, 1, 16'h2222, 0, 0);
        add(150, 1, PRE,  5, 2, 0, 0, 0);
        add(160, 1, PRE,  0, 0, 0, 0, 0);
        add(180, 1, RD0,  2, 1, 0, 10'h3FF, 2);
        add(181, 1, RD0,  2, 1, 0, 10'h3FF, 0);
        add(183, 1, RD1,  2, 1, 0, 10'h3FF, 0);
        run_table();
        drain();
        chk_stats(3, 2, 0, 3);

        // Write window, write recovery, mismatched column pair.
        do_reset();
        vt.delete();
        add(0,   1, ACT0, 1, 3, 16'hBEEF, 0, 0);
        add(2,   1, ACT1, 1, 3, 16'hBEEF, 0, 0);
        add(41,  1, WR0,  1, 3, 0, 10'h2AA, 0);
        add(43,  1, WR1,  1, 3, 0, 10'h2AA, 0);
        add(60,  1, WR0,  1, 3, 0, 10'h2AA, 6);
        add(85,  1, RD0,  1, 3, 0, 10'h2AA, 6);
        add(118, 1, PRE,  1, 3, 0, 0, 3);
        add(119, 1, PRE,  1, 3, 0, 0, 0);
        add(130, 1, ACT0, 1, 3, 16'h0001, 0, 5);
        add(158, 1, ACT0, 1, 3, 16'h0001, 0, 0);
        add(160, 1, ACT1, 1, 3, 16'h0001, 0, 0);
        add(199, 1, RD0,  1, 3, 0, 10'h001, 0);
        add(201, 1, RD1,  1, 3, 0, 10'h002, 4);
        add(210, 1, RD0,  1, 3, 0, 10'h005, 0);
        add(212, 1, RD1,  1, 3, 0, 10'h005, 0);
        run_table();
        drain();
        chk_stats(2, 1, 1, 1);

        // Broken pairs: missing, stray, mismatched row, early second half.
        do_reset();
        vt.delete();
        add(5,   1, ACT0, 3, 0, 16'h0042, 0, 0);
        add(7,   0, ACT0, 0, 0, 0, 0, 4);
        add(8,   1, ACT1, 3, 0, 16'h0042, 0, 4);
        add(60,  1, RD0,  3, 0, 0, 10'h001, 2);
        add(70,  1, ACT0, 3, 0, 16'h0042, 0, 0);
        add(72,  1, ACT1, 3, 0, 16'h0043, 0, 4);
        add(100, 1, RD0,  3, 0, 0, 10'h001, 2);
        add(130, 1, ACT0, 3, 0, 16'h0042, 0, 0);
        add(131, 1, ACT1, 3, 0, 16'h0042, 0, 4);
        add(140, 1, RD0,  3, 0, 0, 10'h001, 2);
        add(150, 1, ACT0, 3, 0, 16'h0042, 0, 0);
        add(152, 1, ACT1, 3, 0, 16'h0042, 0, 0);
        add(191, 1, RD0,  3, 0, 0, 10'h0C3, 0);
        add(193, 1, RD1,  3, 0, 0, 10'h0C3, 0);
        run_table();
        drain();
        chk_stats(1, 1, 0, 0);

        // Reset during beat 3 of a read burst.
        do_reset();
        vt.delete();
        add(10, 1, ACT0, 4, 2, 16'h00AB, 0, 0);
        add(12, 1, ACT1, 4, 2, 16'h00AB, 0, 0);
        add(51, 1, RD0,  4, 2, 0, 10'h0AB, 0);
        add(53, 1, RD1,  4, 2, 0, 10'h0AB, 0);
        run_table();
        while (cyc < 96) step();
        chk("pre_reset_beat", 32'(burst_beat), 3);
        chk_stats(1, 1, 0, 0);
        rst = 1'b1;
        bq.delete();
        step();
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_beat", 32'(burst_beat), 0);
        chk_stats(0, 0, 0, 0);
        rst = 1'b0;
        cyc = 0;
        vt.delete();
        add(5,  1, RD0,  4, 2, 0, 10'h0AB, 2);
        add(10, 1, ACT0, 4, 2, 16'h00AB, 0, 0);
        add(12, 1, ACT1, 4, 2, 16'h00AB, 0, 0);
        run_table();
        drain();
        chk_stats(1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
